// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} dmem_state_t;

    localparam int WORD_BYTES = 4;

    // Request fields captured at the accept edge
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    // Response fields held until the requester takes them
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    // Misaligned or beyond the last word. The 33-bit compare keeps large depths from overflowing.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [32:0] lim;
        lim = 33'(depth) * 33'(WORD_BYTES);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables, async clear and combinational read.
module dmem_array
#(
    parameter int DEPTH = 256
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_be,
    output logic [31:0]              o_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][31:0] w_words;

    genvar gi, gl;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic w_sel;
            assign w_sel = i_we && (i_idx == AW'(gi));
            for (gl = 0; gl < 4; gl++) begin : g_lane
                logic [7:0] r_byte;
                // One byte lane of one word: cleared on reset, written when its enable is set
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_byte <= '0;
                    end else if (w_sel && i_be[gl]) begin
                        r_byte <= i_wdata[8*gl +: 8];
                    end
                end
                assign w_words[gi][8*gl +: 8] = r_byte;
            end
        end
    endgenerate

    assign o_rdata = w_words[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder for the core's data-memory port: accepts one request, waits a fixed number
// of cycles, performs the access, then holds the response until it is taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t r_state;
    dmem_state_t w_state_next;
    logic [3:0]  r_wait_cnt;
    dmem_req_t   r_req;
    dmem_rsp_t   r_rsp;
    logic        r_rsp_valid;

    logic          w_accept;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_do_access;
    logic          w_mem_we;
    logic          w_rsp_take;
    logic [31:0]   w_rd_word;

    assign w_accept    = req_valid && req_ready;
    assign w_err       = addr_err(r_req.addr, DEPTH);
    assign w_idx       = r_req.addr[AW+1:2];
    // First RESP cycle performs the access; later RESP cycles just hold the result.
    assign w_do_access = (r_state == ST_RESP) && !r_rsp_valid;
    assign w_mem_we    = w_do_access && r_req.we && !w_err;
    assign w_rsp_take  = r_rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and request-side handshake
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_take) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (w_accept) begin
            r_wait_cnt <= WAIT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // Request latch: fields captured only on an accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= '0;
        end else if (w_accept) begin
            r_req <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
        end
    end

    // Response registers: set when the access is performed, cleared once taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else if (w_do_access) begin
            r_rsp_valid <= 1'b1;
            r_rsp.err   <= w_err;
            r_rsp.rdata <= (r_req.we || w_err) ? 32'd0 : w_rd_word;
        end else if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_idx   (w_idx),
        .i_wdata (r_req.wdata),
        .i_be    (r_req.be),
        .o_rdata (w_rd_word)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp.rdata;
    assign rsp_err   = r_rsp.err;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) checked against a
// word-array reference model kept in the bench.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        req_valid_s [2];
    logic        req_ready_s [2];
    logic        rsp_valid_s [2];
    logic        rsp_ready_s [2];
    logic [31:0] rsp_rdata_s [2];
    logic        rsp_err_s   [2];
    logic        busy_s      [2];

    logic [31:0] model_mem [2][DEPTH];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]), .rsp_rdata(rsp_rdata_s[0]),
        .rsp_err(rsp_err_s[0]), .busy(busy_s[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]), .rsp_rdata(rsp_rdata_s[1]),
        .rsp_err(rsp_err_s[1]), .busy(busy_s[1])
    );

    // Expected accept-to-response latency per instance
    function automatic int exp_lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                model_mem[d][i] = 32'd0;
    endtask

    // Reference behaviour: a plain word array with byte-lane merge
    task automatic model_apply(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               output logic [31:0] rd, output logic er);
        int idx;
        er = ((addr % 4) != 0) || (addr >= 32'(DEPTH * 4));
        rd = 32'd0;
        if (!er) begin
            idx = int'(addr / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = model_mem[d][idx];
            end
        end
    endtask

    // Drive one full transaction; report latency, response and whether the handshake behaved
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int stall,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic stable, output logic rdy_after);
        stable = 1'b1;
        lat    = 0;
        @(posedge clk); #1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid_s[d] = 1'b1;
        rsp_ready_s[d] = 1'b0;
        @(posedge clk); #1;
        req_valid_s[d] = 1'b0;
        if (req_ready_s[d] !== 1'b0 || busy_s[d] !== 1'b1) stable = 1'b0;
        while (rsp_valid_s[d] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (req_ready_s[d] !== 1'b0 || busy_s[d] !== 1'b1) stable = 1'b0;
        end
        rd = rsp_rdata_s[d];
        er = rsp_err_s[d];
        repeat (stall) begin
            @(posedge clk); #1;
            if (rsp_valid_s[d] !== 1'b1 || rsp_rdata_s[d] !== rd || rsp_err_s[d] !== er ||
                req_ready_s[d] !== 1'b0) stable = 1'b0;
        end
        rsp_ready_s[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_s[d] = 1'b0;
        rdy_after = req_ready_s[d] && !busy_s[d] && !rsp_valid_s[d];
        $display("txn dut=%0d we=%0b addr=%08h wdata=%08h be=%04b stall=%0d -> lat=%0d rdata=%08h err=%0b",
                 d, we, addr, wdata, be, stall, lat, rd, er);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready_s[d] !== 1'b1) begin errors++; $display("FAIL reset_req_ready dut%0d got %b want 1", d, req_ready_s[d]); end
            checks++; if (rsp_valid_s[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid dut%0d got %b want 0", d, rsp_valid_s[d]); end
            checks++; if (rsp_rdata_s[d] !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata dut%0d got %08h want 0", d, rsp_rdata_s[d]); end
            checks++; if (rsp_err_s[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err dut%0d got %b want 0", d, rsp_err_s[d]); end
            checks++; if (busy_s[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy_s[d]); end
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd, erd; logic er, eer, st, ra;
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        checks++; if (lat != 1) begin errors++; $display("FAIL basic_store_lat got %0d want 1", lat); end
        checks++; if (rd !== erd || er !== eer) begin errors++; $display("FAIL basic_store_rsp got %08h/%b want %08h/%b", rd, er, erd, eer); end
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        checks++; if (lat != 1) begin errors++; $display("FAIL basic_load_lat got %0d want 1", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL basic_load_rsp got %08h/%b want deadbeef/0", rd, er); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", ra); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd, erd; logic er, eer, st, ra;
        do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
        do_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, eer);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        checks++; if (rd !== 32'h11BB33DD || er !== 1'b0) begin errors++; $display("FAIL byte_lanes got %08h/%b want 11bb33dd/0", rd, er); end
    endtask

    task automatic test_be_zero();
        int lat; logic [31:0] rd, erd; logic er, eer, st, ra;
        do_txn(0, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, erd, eer);
        do_txn(0, 1'b1, 32'h4, 32'h12345678, 4'h0, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b1, 32'h4, 32'h12345678, 4'h0, erd, eer);
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL be_zero_store got %08h/%b want 0/0", rd, er); end
        do_txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b0, 32'h4, 32'h0, 4'h0, erd, eer);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL be_zero_load got %08h want cafef00d", rd); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd, erd; logic er, eer, st, ra;
        do_txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, lat, rd, er, st, ra);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_misaligned got %08h/%b want 0/1", rd, er); end
        // Out-of-range store would alias onto word 0 if the range check were missing
        do_txn(0, 1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, erd, eer);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_range_store got %08h/%b want 0/1", rd, er); end
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        checks++; if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL err_array_unchanged got %08h/%b want %08h/0", rd, er, erd); end
        do_txn(0, 1'b1, 32'((DEPTH - 1) * 4), 32'h600DF00D, 4'hF, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b1, 32'((DEPTH - 1) * 4), 32'h600DF00D, 4'hF, erd, eer);
        do_txn(0, 1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'h0, 0, lat, rd, er, st, ra);
        model_apply(0, 1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'h0, erd, eer);
        checks++; if (er !== 1'b0 || rd !== 32'h600DF00D) begin errors++; $display("FAIL err_top_word got %08h/%b want 600df00d/0", rd, er); end
    endtask

    task automatic test_stall();
        int lat; logic [31:0] rd, erd; logic er, eer, st, ra;
        do_txn(1, 1'b1, 32'h40, 32'h0BADC0DE, 4'hF, 0, lat, rd, er, st, ra);
        model_apply(1, 1'b1, 32'h40, 32'h0BADC0DE, 4'hF, erd, eer);
        checks++; if (lat != 4) begin errors++; $display("FAIL stall_store_lat got %0d want 4", lat); end
        do_txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 5, lat, rd, er, st, ra);
        model_apply(1, 1'b0, 32'h40, 32'h0, 4'h0, erd, eer);
        checks++; if (lat != 4) begin errors++; $display("FAIL stall_load_lat got %0d want 4", lat); end
        checks++; if (rd !== 32'h0BADC0DE || er !== 1'b0) begin errors++; $display("FAIL stall_load_rsp got %08h/%b want 0badc0de/0", rd, er); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", st); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL stall_ready_after got %b want 1", ra); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd, erd; logic er, eer, st, ra;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h5; req_be = 4'hF;
        req_valid_s[1] = 1'b1;
        @(posedge clk); #1;
        req_valid_s[1] = 1'b0;
        checks++; if (busy_s[1] !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy_s[1]); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid_s[1] !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid got %b want 0", rsp_valid_s[1]); end
        checks++; if (req_ready_s[1] !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got %b want 1", req_ready_s[1]); end
        checks++; if (busy_s[1] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_s[1]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        do_txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er, st, ra);
        model_apply(1, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL midrst_load got %08h/%b want 0/0", rd, er); end
    endtask

    task automatic test_random_back_to_back();
        int lat, d, r, stall; logic [31:0] rd, erd, addr, wdata; logic er, eer, st, ra, we; logic [3:0] be;
        for (int n = 0; n < 40; n++) begin
            d     = int'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            stall = int'($urandom_range(0, 2));
            r     = int'($urandom_range(0, 9));
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'($urandom_range(0, DEPTH * 4 - 1));
            else if (r == 2) addr = 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
            else             addr = 32'(4 * $urandom_range(0, 15));
            do_txn(d, we, addr, wdata, be, stall, lat, rd, er, st, ra);
            model_apply(d, we, addr, wdata, be, erd, eer);
            checks++; if (lat != exp_lat(d)) begin errors++; $display("FAIL rand%0d_lat got %0d want %0d", n, lat, exp_lat(d)); end
            checks++; if (rd !== erd) begin errors++; $display("FAIL rand%0d_rdata got %08h want %08h", n, rd, erd); end
            checks++; if (er !== eer) begin errors++; $display("FAIL rand%0d_err got %b want %b", n, er, eer); end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand%0d_hold got %b want 1", n, st); end
            checks++; if (ra !== 1'b1) begin errors++; $display("FAIL rand%0d_ready_after got %b want 1", n, ra); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        for (int d = 0; d < 2; d++) begin
            req_valid_s[d] = 1'b0;
            rsp_ready_s[d] = 1'b0;
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_byte_lanes();
        test_be_zero();
        test_errors();
        test_stall();
        test_reset_mid();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule
